game_seq: RTL and testbench

//  Game-state sequencer for the Pacman top level. Takes event pulses from the

---
 rtl/game_seq.sv | 217 +++++++++++++++++++++
 tb/tb_game_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq.sv
// Pacman game-state sequencer: edge-detected events drive the IDLE/READY/PLAY/
// DYING/CLEAR/OVER flow, fright timing, lives/level and a saturating BCD score.
module game_seq #(
   parameter int          START_LIVES = 3,
   parameter logic [15:0] PELLET_PTS  = 16'h0010,
   parameter logic [15:0] POWER_PTS   = 16'h0050,
   parameter logic [15:0] GHOST_PTS   = 16'h0200,
   parameter int          FRIGHT_MS   = 6000,
   parameter int          READY_MS    = 2000,
   parameter int          DEATH_MS    = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1ms,
   input  logic        btn_start,
   input  logic        ev_pellet,
   input  logic        ev_power,
   input  logic        ev_ghost,
   input  logic        ev_clear,
   output logic [2:0]  state,
   output logic        freeze,
   output logic        frightened,
   output logic        board_reset,
   output logic [1:0]  lives,
   output logic [3:0]  level,
   output logic [15:0] score
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DYING = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam int EV_START  = 4;
   localparam int EV_PELLET = 3;
   localparam int EV_POWER  = 2;
   localparam int EV_GHOST  = 1;
   localparam int EV_CLEAR  = 0;

   localparam logic [15:0] READY_LAST  = 16'(READY_MS - 1);
   localparam logic [15:0] DEATH_LAST  = 16'(DEATH_MS - 1);
   localparam logic [15:0] FRIGHT_LOAD = 16'(FRIGHT_MS);
   localparam logic [15:0] GVAL_CAP    = 16'h1600;
   localparam logic [15:0] SCORE_MAX   = 16'h9999;

   logic [4:0]  ev_in, ev_d_q, rise_q;
   state_t      st_q;
   logic        freeze_q, fr_q, brst_q;
   logic [1:0]  lives_q;
   logic [3:0]  level_q;
   logic [15:0] score_q, gval_q, ftmr_q, cnt_q;
   logic [15:0] pts, score_d, gval_d;
   logic        ghost_hit;

   // Four-digit BCD add; bit 16 is the carry out of the thousands digit.
   function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
      logic [4:0]  d;
      logic        c;
      logic [15:0] s;
      c = 1'b0;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
         if (d > 5'd9) begin
            d = d + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[4*i +: 4] = d[3:0];
      end
      return {c, s};
   endfunction

   function automatic logic [15:0] sat_bcd(input logic [16:0] r);
      return r[16] ? SCORE_MAX : r[15:0];
   endfunction

   function automatic logic [15:0] dbl_gval(input logic [15:0] g);
      logic [16:0] r;
      r = bcd_add(g, g);
      return (r[16] || (r[15:0] > GVAL_CAP)) ? GVAL_CAP : r[15:0];
   endfunction

   assign ev_in = {btn_start, ev_pellet, ev_power, ev_ghost, ev_clear};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_d_q <= '0;
         rise_q <= '0;
      end else begin
         ev_d_q <= ev_in;
         rise_q <= ev_in & ~ev_d_q;
      end
   end

   // All point sources of one cycle merge into a single saturating add.
   always_comb begin
      ghost_hit = rise_q[EV_GHOST] & fr_q;
      pts       = sat_bcd(bcd_add(rise_q[EV_PELLET] ? PELLET_PTS : 16'h0000,
                                  rise_q[EV_POWER]  ? POWER_PTS  : 16'h0000));
      pts       = sat_bcd(bcd_add(pts, ghost_hit ? gval_q : 16'h0000));
      score_d   = sat_bcd(bcd_add(score_q, pts));
      gval_d    = gval_q;
      if (rise_q[EV_POWER])
         gval_d = GHOST_PTS;
      else if (ghost_hit)
         gval_d = dbl_gval(gval_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q     <= S_IDLE;
         freeze_q <= 1'b1;
         fr_q     <= 1'b0;
         brst_q   <= 1'b0;
         lives_q  <= '0;
         level_q  <= '0;
         score_q  <= '0;
         gval_q   <= GHOST_PTS;
         ftmr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         brst_q <= 1'b0;
         case (st_q)
            S_IDLE, S_OVER: begin
               if (rise_q[EV_START]) begin
                  st_q    <= S_READY;
                  score_q <= '0;
                  lives_q <= 2'(START_LIVES);
                  level_q <= 4'd1;
                  brst_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_READY: begin
               if (tick_1ms) begin
                  if (cnt_q == READY_LAST) begin
                     st_q     <= S_PLAY;
                     freeze_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
            end
            S_PLAY: begin
               score_q <= score_d;
               gval_q  <= gval_d;
               // Death outranks clear; either exit drops fright regardless of a power edge.
               if (rise_q[EV_GHOST] && !fr_q) begin
                  st_q     <= S_DYING;
                  freeze_q <= 1'b1;
                  fr_q     <= 1'b0;
                  ftmr_q   <= '0;
                  cnt_q    <= '0;
               end else if (rise_q[EV_CLEAR]) begin
                  st_q     <= S_CLEAR;
                  freeze_q <= 1'b1;
                  fr_q     <= 1'b0;
                  ftmr_q   <= '0;
                  cnt_q    <= '0;
               end else if (rise_q[EV_POWER]) begin
                  fr_q   <= 1'b1;
                  ftmr_q <= FRIGHT_LOAD;
               end else if (fr_q && tick_1ms) begin
                  ftmr_q <= ftmr_q - 16'd1;
                  if (ftmr_q == 16'd1)
                     fr_q <= 1'b0;
               end
            end
            S_DYING: begin
               if (tick_1ms) begin
                  if (cnt_q == DEATH_LAST) begin
                     lives_q <= lives_q - 2'd1;
                     cnt_q   <= '0;
                     if (lives_q == 2'd1) begin
                        st_q <= S_OVER;
                     end else begin
                        st_q   <= S_READY;
                        brst_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
            end
            S_CLEAR: begin
               if (tick_1ms) begin
                  if (cnt_q == READY_LAST) begin
                     if (level_q != 4'd15)
                        level_q <= level_q + 4'd1;
                     st_q   <= S_READY;
                     brst_q <= 1'b1;
                     cnt_q  <= '0;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign state       = st_q;
   assign freeze      = freeze_q;
   assign frightened  = fr_q;
   assign board_reset = brst_q;
   assign lives       = lives_q;
   assign level       = level_q;
   assign score       = score_q;

endmodule

// File: tb/tb_game_seq.sv
// Bench for game_seq: scenario tasks with a score/state scoreboard fed by an
// independent decimal model of the scoring rules.
module tb_game_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick_1ms = 1'b0;
   logic        btn_start = 1'b0;
   logic        ev_pellet = 1'b0;
   logic        ev_power = 1'b0;
   logic        ev_ghost = 1'b0;
   logic        ev_clear = 1'b0;
   logic [2:0]  state;
   logic        freeze, frightened, board_reset;
   logic [1:0]  lives;
   logic [3:0]  level;
   logic [15:0] score;

   bit tick_en = 1'b0;
   int tick_seen = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] score;
      logic [2:0]  st;
      logic        fr;
   } exp_t;

   exp_t       sb[$];
   int         m_score = 0;
   int         m_gval = 200;
   bit         m_fr = 1'b0;
   logic [2:0] m_st = 3'd0;

   game_seq dut (
      .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .btn_start(btn_start),
      .ev_pellet(ev_pellet), .ev_power(ev_power), .ev_ghost(ev_ghost), .ev_clear(ev_clear),
      .state(state), .freeze(freeze), .frightened(frightened), .board_reset(board_reset),
      .lives(lives), .level(level), .score(score)
   );

   always #5 clk = ~clk;

   // Tick strobe on alternate cycles while enabled.
   always @(negedge clk) tick_1ms = tick_en ? ~tick_1ms : 1'b0;
   always @(posedge clk) if (tick_1ms) tick_seen <= tick_seen + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic drive_evt(input bit p, input bit pw, input bit g, input bit c);
      exp_t e;
      int   pts;
      bit   fr0;
      fr0 = m_fr;
      pts = (p ? 10 : 0) + (pw ? 50 : 0) + ((g && fr0) ? m_gval : 0);
      if (g && fr0) m_gval = (m_gval * 2 > 1600) ? 1600 : m_gval * 2;
      if (pw) begin
         m_fr   = 1'b1;
         m_gval = 200;
      end
      m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
      if (g && !fr0) begin
         m_st = 3'd3;
         m_fr = 1'b0;
      end else if (c) begin
         m_st = 3'd4;
         m_fr = 1'b0;
      end
      e.score = to_bcd(m_score);
      e.st    = m_st;
      e.fr    = m_fr;
      sb.push_back(e);
      @(negedge clk);
      ev_pellet = p; ev_power = pw; ev_ghost = g; ev_clear = c;
      @(negedge clk);
      ev_pellet = 1'b0; ev_power = 1'b0; ev_ghost = 1'b0; ev_clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 4 * (target - tick_seen) + 20;
      while (tick_seen < target && guard > 0) begin
         @(posedge clk);
         #1;
         guard--;
      end
      if (tick_seen < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL tick_wait: reached %0d ticks, required %0d", tick_seen, target);
      end
   endtask

   task automatic start_game(input string tag);
      int t0;
      tick_en = 1'b1;
      @(negedge clk) btn_start = 1'b1;
      @(negedge clk) btn_start = 1'b0;
      @(negedge clk);
      t0 = tick_seen;
      n_tests++;
      if ({state, board_reset, lives, level, score, freeze} !== {3'd1, 1'b1, 2'd3, 4'd1, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL %s_ready: st=%0d brst=%b lives=%0d lvl=%0d score=%h frz=%b, required 1 1 3 1 0000 1",
                  tag, state, board_reset, lives, level, score, freeze);
      end
      @(negedge clk);
      n_tests++;
      if (board_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_brst_pulse: board_reset=%b, required 0", tag, board_reset);
      end
      wait_until(t0 + 1999);
      n_tests++;
      if (state !== 3'd1) begin
         n_fail++;
         $display("FAIL %s_ready_hold: state=%0d, required 1", tag, state);
      end
      wait_until(t0 + 2000);
      n_tests++;
      if ({state, freeze} !== {3'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL %s_play: state=%0d freeze=%b, required 2 0", tag, state, freeze);
      end
      m_score = 0; m_gval = 200; m_fr = 1'b0; m_st = 3'd2;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({state, freeze, frightened, board_reset, lives, level, score} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_values: st=%0d frz=%b fr=%b brst=%b lives=%0d lvl=%0d score=%h",
                  state, freeze, frightened, board_reset, lives, level, score);
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_tests++;
      if ({state, freeze, score} !== {3'd0, 1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL idle_after_release: st=%0d frz=%b score=%h, required 0 1 0000", state, freeze, score);
      end
   endtask

   task automatic test_start();
      start_game("start");
   endtask

   task automatic test_pellet();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive_evt(1'b1, 1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         n_tests++;
         if ({score, state, frightened} !== {e.score, e.st, e.fr}) begin
            n_fail++;
            $display("FAIL pellet%0d: score=%h st=%0d fr=%b, required %h %0d %b", i, score, state, frightened, e.score, e.st, e.fr);
         end
      end
      m_score = m_score + 10;
      e.score = to_bcd(m_score); e.st = m_st; e.fr = m_fr;
      sb.push_back(e);
      @(negedge clk) ev_pellet = 1'b1;
      repeat (10) @(negedge clk);
      ev_pellet = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (score !== e.score || score !== 16'h0040) begin
         n_fail++;
         $display("FAIL pellet_held: score=%h, required %h", score, e.score);
      end
   endtask

   task automatic test_fright();
      exp_t e;
      int   t0;
      drive_evt(1'b0, 1'b1, 1'b0, 1'b0);
      t0 = tick_seen;
      e = sb.pop_front();
      n_tests++;
      if ({score, state, frightened} !== {e.score, e.st, e.fr}) begin
         n_fail++;
         $display("FAIL power: score=%h st=%0d fr=%b, required %h %0d %b", score, state, frightened, e.score, e.st, e.fr);
      end
      for (int i = 0; i < 4; i++) begin
         drive_evt(1'b0, 1'b0, 1'b1, 1'b0);
         e = sb.pop_front();
         n_tests++;
         if ({score, state, frightened} !== {e.score, e.st, e.fr}) begin
            n_fail++;
            $display("FAIL ghost%0d: score=%h st=%0d fr=%b, required %h %0d %b", i, score, state, frightened, e.score, e.st, e.fr);
         end
      end
      n_tests++;
      if (score !== 16'h3090) begin
         n_fail++;
         $display("FAIL fright_total: score=%h, required 3090", score);
      end
      wait_until(t0 + 5999);
      n_tests++;
      if (frightened !== 1'b1) begin
         n_fail++;
         $display("FAIL fright_hold: frightened=%b, required 1", frightened);
      end
      wait_until(t0 + 6000);
      n_tests++;
      if (frightened !== 1'b0) begin
         n_fail++;
         $display("FAIL fright_end: frightened=%b, required 0", frightened);
      end
      m_fr = 1'b0;
   endtask

   task automatic test_death();
      exp_t e;
      int   t0, t1;
      for (int k = 0; k < 3; k++) begin
         drive_evt(1'b1, 1'b0, 1'b1, 1'b1);
         t0 = tick_seen;
         e = sb.pop_front();
         n_tests++;
         if ({score, state, frightened, freeze} !== {e.score, e.st, e.fr, 1'b1}) begin
            n_fail++;
            $display("FAIL death%0d_enter: score=%h st=%0d fr=%b frz=%b, required %h %0d %b 1",
                     k, score, state, frightened, freeze, e.score, e.st, e.fr);
         end
         wait_until(t0 + 1999);
         n_tests++;
         if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL death%0d_hold: state=%0d, required 3", k, state);
         end
         wait_until(t0 + 2000);
         if (k < 2) begin
            n_tests++;
            if ({state, board_reset, lives} !== {3'd1, 1'b1, 2'(2 - k)}) begin
               n_fail++;
               $display("FAIL death%0d_exit: st=%0d brst=%b lives=%0d, required 1 1 %0d", k, state, board_reset, lives, 2 - k);
            end
            t1 = tick_seen;
            wait_until(t1 + 2000);
            n_tests++;
            if (state !== 3'd2) begin
               n_fail++;
               $display("FAIL death%0d_replay: state=%0d, required 2", k, state);
            end
            m_st = 3'd2;
         end else begin
            n_tests++;
            if ({state, lives, freeze, board_reset} !== {3'd5, 2'd0, 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL game_over: st=%0d lives=%0d frz=%b brst=%b, required 5 0 1 0", state, lives, freeze, board_reset);
            end
         end
      end
      start_game("restart");
   endtask

   task automatic test_clear();
      exp_t e;
      int   t0, t1;
      drive_evt(1'b1, 1'b0, 1'b0, 1'b1);
      t0 = tick_seen;
      e = sb.pop_front();
      n_tests++;
      if ({score, state, frightened} !== {e.score, e.st, e.fr}) begin
         n_fail++;
         $display("FAIL clear_enter: score=%h st=%0d fr=%b, required %h %0d %b", score, state, frightened, e.score, e.st, e.fr);
      end
      wait_until(t0 + 2000);
      n_tests++;
      if ({state, level, board_reset, lives, score} !== {3'd1, 4'd2, 1'b1, 2'd3, to_bcd(m_score)}) begin
         n_fail++;
         $display("FAIL clear_exit: st=%0d lvl=%0d brst=%b lives=%0d score=%h, required 1 2 1 3 %h",
                  state, level, board_reset, lives, score, to_bcd(m_score));
      end
      t1 = tick_seen;
      wait_until(t1 + 2000);
      n_tests++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("FAIL clear_replay: state=%0d, required 2", state);
      end
      m_st = 3'd2;
   endtask

   task automatic test_saturate();
      exp_t e;
      tick_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 42; i++) begin
         if (i == 0 || i == 9)
            drive_evt(1'b0, 1'b1, 1'b0, 1'b0);
         else if (i <= 10)
            drive_evt(1'b0, 1'b0, 1'b1, 1'b0);
         else
            drive_evt(1'b1, 1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         n_tests++;
         if ({score, state, frightened} !== {e.score, e.st, e.fr}) begin
            n_fail++;
            $display("FAIL sat_step%0d: score=%h st=%0d fr=%b, required %h %0d %b", i, score, state, frightened, e.score, e.st, e.fr);
         end
      end
      n_tests++;
      if (score !== 16'h9999) begin
         n_fail++;
         $display("FAIL score_saturate: score=%h, required 9999", score);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      n_tests++;
      if (frightened !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_fright: frightened=%b, required 1", frightened);
      end
      @(negedge clk);
      reset = 1'b0;
      ev_pellet = 1'b1;
      #1;
      n_tests++;
      if ({state, freeze, frightened, board_reset, lives, level, score} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL async_reset_fright: st=%0d frz=%b fr=%b brst=%b lives=%0d lvl=%0d score=%h",
                  state, freeze, frightened, board_reset, lives, level, score);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      start_game("reset_mid");
      repeat (5) @(negedge clk);
      n_tests++;
      if (score !== 16'h0000) begin
         n_fail++;
         $display("FAIL held_event_release: score=%h, required 0000", score);
      end
      ev_pellet = 1'b0;
      @(negedge clk);
      drive_evt(1'b0, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if ({score, state} !== {e.score, e.st}) begin
         n_fail++;
         $display("FAIL reset_mid_death: score=%h st=%0d, required %h %0d", score, state, e.score, e.st);
      end
      wait_until(tick_seen + 100);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if ({state, freeze, frightened, board_reset, lives, level, score} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL async_reset_dying: st=%0d frz=%b fr=%b brst=%b lives=%0d lvl=%0d score=%h",
                  state, freeze, frightened, board_reset, lives, level, score);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_start();
      test_pellet();
      test_fright();
      test_death();
      test_clear();
      test_saturate();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
